// File: rtl/execution_unit_pkg.sv
// Shared EX-stage definitions: datapath width, ALU op codes, EX/ME bundle.
// Imported by the decode unit as well.
package execution_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_AUIPC = 4'b1011;
    localparam logic [3:0] ALU_JAL  = 4'b1100;
    localparam logic [3:0] ALU_JALR = 4'b1101;
    localparam logic [3:0] ALU_BNE  = 4'b1110;
    localparam logic [3:0] ALU_BGE  = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] branch_pc;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch_taken;
    } ex_me_t;

endpackage

// File: rtl/execution_unit_alu.sv
// Combinational RV32 ALU: arithmetic/logic result plus a compare flag
// used by the branch-taken logic.
module alu
    import execution_unit_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] res,
    output logic            cmp_true
);

    logic [XLEN-1:0] w_diff;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [4:0]      w_shamt;

    assign w_diff  = a - b;
    assign w_eq    = (a == b);
    assign w_lt_s  = ($signed(a) < $signed(b));
    assign w_lt_u  = (a < b);
    assign w_shamt = b[4:0];

    always_comb begin
        res = '0;
        unique case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = w_diff;
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_SLL:   res = a << w_shamt;
            ALU_SRL:   res = a >> w_shamt;
            ALU_SRA:   res = $signed(a) >>> w_shamt;
            ALU_SLT:   res = {{(XLEN-1){1'b0}}, w_lt_s};
            ALU_SLTU:  res = {{(XLEN-1){1'b0}}, w_lt_u};
            ALU_LUI:   res = imm;
            ALU_AUIPC: res = pc + imm;
            ALU_JAL:   res = pc + 32'd4;
            ALU_JALR:  res = pc + 32'd4;
            ALU_BNE:   res = w_diff;
            ALU_BGE:   res = w_diff;
        endcase
    end

    // SUB doubles as BEQ, SLT/SLTU as BLT/BLTU.
    always_comb begin
        cmp_true = 1'b0;
        unique case (op)
            ALU_SUB:  cmp_true = w_eq;
            ALU_BNE:  cmp_true = !w_eq;
            ALU_SLT:  cmp_true = w_lt_s;
            ALU_SLTU: cmp_true = w_lt_u;
            ALU_BGE:  cmp_true = !w_lt_s;
            ALU_JAL:  cmp_true = 1'b1;
            ALU_JALR: cmp_true = 1'b1;
            default:  cmp_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/execution_unit.sv
// EX stage: operand select, ALU, branch target/decision and the EX/ME
// pipeline register (loads every cycle, synchronous active-low reset).
module execution_unit
    import execution_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ID_EX_rs1,
    input  logic [XLEN-1:0] ID_EX_rs2,
    input  logic [XLEN-1:0] ID_EX_PC,
    input  logic [XLEN-1:0] ID_EX_imm,
    input  logic [4:0]      ID_EX_rd,
    input  logic            ID_EX_ALU_src,
    input  logic            ID_EX_branch,
    input  logic            ID_EX_RegWrite,
    input  logic            ID_EX_MemRead,
    input  logic            ID_EX_MemWrite,
    input  logic            ID_EX_MemtoReg,
    input  logic [3:0]      ID_EX_ALU_op,
    output logic [XLEN-1:0] EX_ME_ALU_result,
    output logic [XLEN-1:0] EX_ME_rs2,
    output logic [XLEN-1:0] EX_ME_branch_PC,
    output logic [4:0]      EX_ME_rd,
    output logic            EX_ME_RegWrite,
    output logic            EX_ME_MemRead,
    output logic            EX_ME_MemWrite,
    output logic            EX_ME_MemtoReg,
    output logic            EX_ME_branch_taken
);

    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_res;
    logic            w_cmp;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic            w_taken;
    ex_me_t          w_next;
    ex_me_t          r_ex_me;

    assign w_op_b = ID_EX_ALU_src ? ID_EX_imm : ID_EX_rs2;

    alu u_alu (
        .a        (ID_EX_rs1),
        .b        (w_op_b),
        .pc       (ID_EX_PC),
        .imm      (ID_EX_imm),
        .op       (ID_EX_ALU_op),
        .res      (w_res),
        .cmp_true (w_cmp)
    );

    // JALR clears bit 0 of the computed target.
    assign w_jalr_sum = ID_EX_rs1 + ID_EX_imm;
    assign w_target   = (ID_EX_ALU_op == ALU_JALR)
                      ? {w_jalr_sum[XLEN-1:1], 1'b0}
                      : ID_EX_PC + ID_EX_imm;
    assign w_taken    = ID_EX_branch & w_cmp;

    always_comb begin
        w_next              = '0;
        w_next.alu_result   = w_res;
        w_next.rs2          = ID_EX_rs2;
        w_next.branch_pc    = w_target;
        w_next.rd           = ID_EX_rd;
        w_next.reg_write    = ID_EX_RegWrite;
        w_next.mem_read     = ID_EX_MemRead;
        w_next.mem_write    = ID_EX_MemWrite;
        w_next.mem_to_reg   = ID_EX_MemtoReg;
        w_next.branch_taken = w_taken;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ex_me <= '0;
        end else begin
            r_ex_me <= w_next;
        end
    end

    assign EX_ME_ALU_result   = r_ex_me.alu_result;
    assign EX_ME_rs2          = r_ex_me.rs2;
    assign EX_ME_branch_PC    = r_ex_me.branch_pc;
    assign EX_ME_rd           = r_ex_me.rd;
    assign EX_ME_RegWrite     = r_ex_me.reg_write;
    assign EX_ME_MemRead      = r_ex_me.mem_read;
    assign EX_ME_MemWrite     = r_ex_me.mem_write;
    assign EX_ME_MemtoReg     = r_ex_me.mem_to_reg;
    assign EX_ME_branch_taken = r_ex_me.branch_taken;

endmodule

// File: tb/tb_execution_unit.sv
// Scoreboard bench for execution_unit: directed cases then random
// stimulus against a behavioural model of the EX stage.
module tb_execution_unit;

    typedef struct {
        logic        rst_n;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        src;
        logic        br;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [3:0]  op;
    } stim_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] bpc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        tk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rs1, rs2, pc, imm;
    logic [4:0]  rd;
    logic        src, br, rw, mr, mw, m2r;
    logic [3:0]  op;
    logic [31:0] o_res, o_rs2, o_bpc;
    logic [4:0]  o_rd;
    logic        o_rw, o_mr, o_mw, o_m2r, o_tk;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    execution_unit dut (
        .clk                (clk),
        .reset              (reset),
        .ID_EX_rs1          (rs1),
        .ID_EX_rs2          (rs2),
        .ID_EX_PC           (pc),
        .ID_EX_imm          (imm),
        .ID_EX_rd           (rd),
        .ID_EX_ALU_src      (src),
        .ID_EX_branch       (br),
        .ID_EX_RegWrite     (rw),
        .ID_EX_MemRead      (mr),
        .ID_EX_MemWrite     (mw),
        .ID_EX_MemtoReg     (m2r),
        .ID_EX_ALU_op       (op),
        .EX_ME_ALU_result   (o_res),
        .EX_ME_rs2          (o_rs2),
        .EX_ME_branch_PC    (o_bpc),
        .EX_ME_rd           (o_rd),
        .EX_ME_RegWrite     (o_rw),
        .EX_ME_MemRead      (o_mr),
        .EX_ME_MemWrite     (o_mw),
        .EX_ME_MemtoReg     (o_m2r),
        .EX_ME_branch_taken (o_tk)
    );

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] b;
        longint      sa, sb;
        longint      ua, ub;
        int          sh;
        bit          cond;
        e = '{default: '0};
        if (!s.rst_n) return e;
        b  = s.src ? s.imm : s.rs2;
        sa = longint'($signed(s.rs1));
        sb = longint'($signed(b));
        ua = longint'({32'd0, s.rs1});
        ub = longint'({32'd0, b});
        sh = int'(b % 32);
        cond = 1'b0;
        case (s.op)
            4'd0:  e.res = 32'(ua + ub);
            4'd1:  e.res = 32'(ua - ub);
            4'd2:  e.res = s.rs1 & b;
            4'd3:  e.res = s.rs1 | b;
            4'd4:  e.res = s.rs1 ^ b;
            4'd5:  e.res = 32'(ua * (64'd1 << sh));
            4'd6:  e.res = 32'(ua / (64'd1 << sh));
            4'd7:  e.res = 32'(sa >>> sh);
            4'd8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  e.res = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: e.res = s.imm;
            4'd11: e.res = s.pc + s.imm;
            4'd12: e.res = s.pc + 32'd4;
            4'd13: e.res = s.pc + 32'd4;
            default: e.res = 32'(ua - ub);
        endcase
        case (s.op)
            4'd1:  cond = (ua == ub);
            4'd14: cond = (ua != ub);
            4'd8:  cond = (sa < sb);
            4'd9:  cond = (ua < ub);
            4'd15: cond = (sa >= sb);
            4'd12, 4'd13: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        e.tk  = s.br && cond;
        if (s.op == 4'd13)
            e.bpc = 32'((ua + longint'({32'd0, s.imm})) / 2 * 2);
        else
            e.bpc = s.pc + s.imm;
        e.rs2 = s.rs2;
        e.rd  = s.rd;
        e.rw  = s.rw;
        e.mr  = s.mr;
        e.mw  = s.mw;
        e.m2r = s.m2r;
        return e;
    endfunction

    function automatic stim_t base(input logic [3:0] o);
        stim_t s;
        s.rst_n = 1'b1; s.rs1 = 32'd10; s.rs2 = 32'd5;
        s.pc = 32'd100; s.imm = 32'd20; s.rd = 5'd1;
        s.src = 1'b0; s.br = 1'b1; s.rw = 1'b1;
        s.mr = 1'b0; s.mw = 1'b0; s.m2r = 1'b0; s.op = o;
        return s;
    endfunction

    task automatic step(input stim_t s);
        @(negedge clk);
        reset = s.rst_n; rs1 = s.rs1; rs2 = s.rs2; pc = s.pc;
        imm = s.imm; rd = s.rd; src = s.src; br = s.br; rw = s.rw;
        mr = s.mr; mw = s.mw; m2r = s.m2r; op = s.op;
        q.push_back(model(s));
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, ex, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result", o_res, e.res);
                chk("rs2", o_rs2, e.rs2);
                chk("branch_PC", o_bpc, e.bpc);
                chk("rd", {27'd0, o_rd}, {27'd0, e.rd});
                chk("RegWrite", {31'd0, o_rw}, {31'd0, e.rw});
                chk("MemRead", {31'd0, o_mr}, {31'd0, e.mr});
                chk("MemWrite", {31'd0, o_mw}, {31'd0, e.mw});
                chk("MemtoReg", {31'd0, o_m2r}, {31'd0, e.m2r});
                chk("taken", {31'd0, o_tk}, {31'd0, e.tk});
            end
        end
    end

    initial begin : driver
        stim_t s;
        reset = 1'b0; rs1 = '0; rs2 = '0; pc = '0; imm = '0; rd = '0;
        src = 0; br = 0; rw = 0; mr = 0; mw = 0; m2r = 0; op = '0;

        s = base(4'd0); s.rst_n = 1'b0;
        step(s); step(s);
        step(base(4'd0));
        step(base(4'd1));
        step(base(4'd10));
        step(base(4'd11));
        step(base(4'd12));
        step(base(4'd13));
        s = base(4'd1); s.rs1 = 32'd7; s.rs2 = 32'd7; step(s);
        s.br = 1'b0; step(s);
        s = base(4'd8); s.rs1 = 32'hFFFF_FFFF; s.rs2 = 32'd1; step(s);
        s.op = 4'd9; step(s);
        s = base(4'd0); s.rd = 5'd31; s.mw = 1'b1;
        s.rs2 = 32'hDEAD_BEEF; step(s);
        s = base(4'd7); s.rs1 = 32'h8000_0010; s.rs2 = 32'd31; step(s);
        s = base(4'd15); s.rs1 = 32'h8000_0000; s.rs2 = 32'd0; step(s);
        s = base(4'd13); s.rs1 = 32'd11; s.imm = 32'd4; step(s);

        for (int i = 0; i < 400; i++) begin
            s.rst_n = ($urandom_range(0, 19) != 0);
            s.rs1 = $urandom;
            s.rs2 = ($urandom_range(0, 3) == 0) ? s.rs1 : $urandom;
            if ($urandom_range(0, 3) == 0) s.rs2 = $urandom_range(0, 40);
            s.pc  = $urandom & 32'hFFFF_FFFC;
            s.imm = $urandom;
            s.rd  = 5'($urandom);
            s.src = 1'($urandom);
            s.br  = 1'($urandom);
            s.rw  = 1'($urandom);
            s.mr  = 1'($urandom);
            s.mw  = 1'($urandom);
            s.m2r = 1'($urandom);
            s.op  = 4'($urandom);
            step(s);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
